uart_rx_engine: RTL and testbench
=================================

UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 Parameter BAUD_DIV, default 868, clock cycles per serial bit; legal range 4..65535.
REQ-002 Parameter FRAME_BITS, default 10, bits per frame: 1 start, 8 data, 1 stop.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 rx  input  1  asynchronous serial line; idles high.
REQ-006 sh  output  1  one-cycle shift strobe to the downstream 10-bit right-shift register.
REQ-007 sdi  output  1  sampled serial bit; valid in every cycle where sh=1.
REQ-008 busy  output  1  high from start-bit detection through frame completion.
REQ-009 rx_done  output  1  one-cycle pulse when a full frame has been shifted out.
REQ-010 ferr  output  1  framing error flag: stop bit sampled as 0; valid with rx_done, held until the next rx_done.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; rx_s denotes the second flop output; all decisions use rx_s only.
REQ-012 The FSM SHALL have states IDLE, START, DATA and DONE, all registered.
REQ-013 IDLE: when rx_s=0, the FSM SHALL go to START, load bit counter cnt=BAUD_DIV/2-1 (integer divide) and set busy=1.
REQ-014 START: cnt SHALL decrement each cycle.
REQ-015 START, at cnt=0 with rx_s=0: the block SHALL pulse sh with sdi=0, set bit_idx=1, load cnt=BAUD_DIV-1 and go to DATA.
REQ-016 START, at cnt=0 with rx_s=1 (false start): the block SHALL return to IDLE with busy=0, no sh pulse and no rx_done.
REQ-017 DATA: cnt SHALL decrement each cycle.
REQ-018 DATA, at cnt=0: the block SHALL pulse sh with sdi=rx_s, increment bit_idx and reload cnt=BAUD_DIV-1.
REQ-019 DATA: the sample taken when bit_idx=FRAME_BITS-1 is the stop bit; after its sh pulse the FSM SHALL go to DONE.
REQ-020 DONE, one cycle: rx_done=1; ferr=~(stop sample); busy=0; next state IDLE.
REQ-021 Exactly FRAME_BITS sh pulses SHALL occur per accepted frame, spaced exactly BAUD_DIV cycles apart.
REQ-022 The first sh pulse SHALL occur BAUD_DIV/2 cycles after the START entry edge.
REQ-023 Downstream register content after rx_done: [0]=start, [8:1]=data LSB-first, [9]=stop.
REQ-024 rx_done SHALL follow the last sh by exactly one cycle.
REQ-025 sh and rx_done SHALL never be high in the same cycle.
REQ-026 rx changes in DATA other than at sample points SHALL be ignored; no resynchronization mid-frame.
REQ-027 A low line in IDLE immediately after DONE SHALL start a new frame (back-to-back frames supported).
REQ-028 A continuously low line (break) SHALL produce a frame with ferr=1, then restart from IDLE.
REQ-029 cnt SHALL be 16 bits wide.
REQ-030 bit_idx SHALL be 4 bits wide and never exceed FRAME_BITS-1.

Reset
REQ-031 While reset=0, regardless of clk: state=IDLE; sh, sdi, busy, rx_done, ferr, cnt and bit_idx =0; synchronizer flops =1.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no further sh or rx_done.
REQ-033 After reset release, the block SHALL wait for a fresh rx_s=0 before starting a frame.

Verification (BAUD_DIV=16)
REQ-034 Send 0xA5, stop=1 -> 10 sh pulses 16 cycles apart; sdi sequence 0,1,0,1,0,0,1,0,1,1; rx_done one cycle after last sh; ferr=0.
REQ-035 4-cycle low glitch on idle rx -> START entered, returns to IDLE at the mid-point check; no sh; busy low afterwards.
REQ-036 Send 0x3C with stop=0 -> rx_done with ferr=1; next frame 0xFF with stop=1 -> ferr=0.
REQ-037 Two frames back-to-back (0x00 then 0xFF, no idle gap) -> 20 sh pulses, two rx_done pulses, both ferr=0.
REQ-038 Assert reset after the 5th sh of a frame -> outputs 0 within the same cycle; no further sh; next clean frame 0x81 received correctly.
REQ-039 Hold rx low for 15 bit times -> first frame ends with ferr=1; a new frame then starts because rx_s is still 0.

Source files
------------

// File: rtl/uart_rx_engine_if.sv
// uart_rx_engine_if: serial line in, shift strobe/bit and frame status out.
//   rx      - serial line (idles high)
//   sh, sdi - one-cycle shift strobe and the sampled bit for a downstream shift register
//   busy    - frame in progress
//   rx_done - one-cycle end-of-frame pulse
//   ferr    - framing error of the last frame, valid with rx_done
interface uart_rx_engine_if;
  logic rx;
  logic sh;
  logic sdi;
  logic busy;
  logic rx_done;
  logic ferr;
  modport master (output rx, input sh, sdi, busy, rx_done, ferr);
  modport slave (input rx, output sh, sdi, busy, rx_done, ferr);
endinterface

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: UART frame sampler that strobes each mid-bit sample into a downstream shift register.
//   clk   - system clock
//   reset - asynchronous active-low reset
//   bus   - uart_rx_engine_if slave: rx in; sh, sdi, busy, rx_done, ferr out (all registered)
module uart_rx_engine #(
  parameter int BAUD_DIV   = 868,
  parameter int FRAME_BITS = 10
) (
  input logic             clk,
  input logic             reset,
  uart_rx_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;
  localparam logic [15:0] HALF = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST = 4'(FRAME_BITS - 1);
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic        sync_q, rx_s;
  logic        sh_q, sh_d, sdi_q, sdi_d, busy_q, busy_d, rx_done_q, rx_done_d, ferr_q, ferr_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= 1'b1;
      rx_s      <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      sh_q      <= 1'b0;
      sdi_q     <= 1'b0;
      busy_q    <= 1'b0;
      rx_done_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= bus.rx;
      rx_s      <= sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      sh_q      <= sh_d;
      sdi_q     <= sdi_d;
      busy_q    <= busy_d;
      rx_done_q <= rx_done_d;
      ferr_q    <= ferr_d;
    end
  end
  // sdi_q still holds the stop sample while in DONE, so ferr is taken from it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    sh_d      = 1'b0;
    sdi_d     = sdi_q;
    busy_d    = busy_q;
    rx_done_d = 1'b0;
    ferr_d    = ferr_q;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        cnt_d   = HALF;
        busy_d  = 1'b1;
      end
      START: if (cnt_q != '0) cnt_d = cnt_q - 16'd1;
      else if (!rx_s) begin
        sh_d      = 1'b1;
        sdi_d     = 1'b0;
        bit_idx_d = 4'd1;
        cnt_d     = FULL;
        state_d   = DATA;
      end else begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      DATA: if (cnt_q != '0) cnt_d = cnt_q - 16'd1;
      else begin
        sh_d      = 1'b1;
        sdi_d     = rx_s;
        cnt_d     = FULL;
        bit_idx_d = (bit_idx_q == LAST) ? 4'd0 : bit_idx_q + 4'd1;
        state_d   = (bit_idx_q == LAST) ? DONE : DATA;
      end
      DONE: begin
        rx_done_d = 1'b1;
        ferr_d    = ~sdi_q;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end
  assign bus.sh      = sh_q;
  assign bus.sdi     = sdi_q;
  assign bus.busy    = busy_q;
  assign bus.rx_done = rx_done_q;
  assign bus.ferr    = ferr_q;
endmodule

// File: tb/tb_uart_rx_engine.sv
// tb_uart_rx_engine: scoreboard bench for uart_rx_engine at BAUD_DIV=16.
module tb_uart_rx_engine;
  localparam int B = 16;
  typedef struct {logic [9:0] fr; logic ferr;} exp_t;
  typedef struct {logic [9:0] fr; logic ferr; int nsh; int gaps; int dgap; int first;} obs_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0, checks = 0;
  int cyc = 0, sh_total = 0, done_total = 0, overlap = 0, t0 = 0;
  int nsh = 0, gaps = 0, last_sh = 0, first_sh = 0;
  logic [9:0] fr = '0;
  bit busy_seen = 0;
  exp_t exp_q[$];
  obs_t obs_q[$];
  uart_rx_engine_if bus ();
  uart_rx_engine #(.BAUD_DIV(B), .FRAME_BITS(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      nsh  = 0;
      gaps = 0;
    end else begin
      if (bus.sh && bus.rx_done) overlap++;
      if (bus.busy) busy_seen = 1;
      if (bus.sh) begin
        if (nsh > 0 && cyc - last_sh != B) gaps++;
        if (nsh == 0) first_sh = cyc;
        last_sh = cyc;
        nsh++;
        sh_total++;
        fr = {bus.sdi, fr[9:1]};
      end
      if (bus.rx_done) begin
        obs_q.push_back('{fr, bus.ferr, nsh, gaps, cyc - last_sh, first_sh});
        nsh  = 0;
        gaps = 0;
        done_total++;
      end
    end
  end
  task automatic bit_(input logic v);
    bus.rx = v;
    repeat (B) @(posedge clk);
    #1;
  endtask
  task automatic align();
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic s);
    exp_q.push_back('{{s, d, 1'b0}, ~s});
    t0 = cyc;
    bit_(1'b0);
    for (int i = 0; i < 8; i++) bit_(d[i]);
    bit_(s);
  endtask
  task automatic wait_obs(output obs_t o, output bit ok);
    ok = 0;
    o = '{'0, 1'b0, 0, 0, 0, 0};
    for (int i = 0; i < 600; i++) begin
      if (obs_q.size() > 0) begin
        o  = obs_q.pop_front();
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    bus.rx = 1'b1;
    reset  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.sh, bus.sdi, bus.busy, bus.rx_done, bus.ferr} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=00000", {bus.sh, bus.sdi, bus.busy, bus.rx_done, bus.ferr});
    end
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (sh_total !== 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle sh_total=%0d busy=%b want 0/0", sh_total, bus.busy);
    end
  endtask
  task automatic test_basic();
    obs_t o;
    exp_t e;
    bit ok;
    align();
    send_frame(8'hA5, 1'b1);
    e = exp_q.pop_front();
    wait_obs(o, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout no rx_done");
    end else begin
      if ({o.fr, o.ferr, o.nsh == 10, o.gaps == 0, o.dgap == 1} !== {e.fr, e.ferr, 3'b111}) begin
        errors++;
        $display("FAIL basic_frame fr=%b ferr=%b nsh=%0d gaps=%0d dgap=%0d want fr=%b ferr=%b nsh=10 gaps=0 dgap=1",
                 o.fr, o.ferr, o.nsh, o.gaps, o.dgap, e.fr, e.ferr);
      end
      checks++;
      if (o.first - t0 !== 3 + B / 2) begin
        errors++;
        $display("FAIL basic_first_sh delay=%0d want=%0d", o.first - t0, 3 + B / 2);
      end
    end
  endtask
  task automatic test_glitch();
    int s0, d0;
    s0 = sh_total;
    d0 = done_total;
    busy_seen = 0;
    align();
    bus.rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if ({sh_total - s0, done_total - d0} !== {32'd0, 32'd0} || busy_seen !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch sh=%0d done=%0d busy_seen=%b busy=%b want 0/0/1/0",
               sh_total - s0, done_total - d0, busy_seen, bus.busy);
    end
  endtask
  task automatic test_ferr();
    obs_t o;
    exp_t e;
    bit ok;
    align();
    send_frame(8'h3C, 1'b0);
    send_frame(8'hFF, 1'b1);
    repeat (2) begin
      e = exp_q.pop_front();
      wait_obs(o, ok);
      checks++;
      if (!ok || {o.fr, o.ferr, o.nsh == 10, o.gaps == 0, o.dgap == 1} !== {e.fr, e.ferr, 3'b111}) begin
        errors++;
        $display("FAIL ferr_frame ok=%b fr=%b ferr=%b nsh=%0d gaps=%0d dgap=%0d want fr=%b ferr=%b",
                 ok, o.fr, o.ferr, o.nsh, o.gaps, o.dgap, e.fr, e.ferr);
      end
    end
  endtask
  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    bit ok;
    int s0, d0;
    s0 = sh_total;
    d0 = done_total;
    align();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (2) begin
      e = exp_q.pop_front();
      wait_obs(o, ok);
      checks++;
      if (!ok || {o.fr, o.ferr, o.nsh == 10, o.gaps == 0, o.dgap == 1} !== {e.fr, e.ferr, 3'b111}) begin
        errors++;
        $display("FAIL b2b_frame ok=%b fr=%b ferr=%b nsh=%0d gaps=%0d dgap=%0d want fr=%b ferr=%b",
                 ok, o.fr, o.ferr, o.nsh, o.gaps, o.dgap, e.fr, e.ferr);
      end
    end
    checks++;
    if (sh_total - s0 !== 20 || done_total - d0 !== 2) begin
      errors++;
      $display("FAIL b2b_counts sh=%0d done=%0d want 20/2", sh_total - s0, done_total - d0);
    end
  endtask
  task automatic test_reset_mid();
    obs_t o;
    exp_t e;
    bit ok;
    int s0, d0;
    logic [7:0] d;
    s0 = sh_total;
    d0 = done_total;
    d  = 8'h55;
    align();
    bit_(1'b0);
    for (int i = 0; i < 4; i++) bit_(d[i]);
    checks++;
    if (sh_total - s0 !== 5) begin
      errors++;
      $display("FAIL midreset_pre sh=%0d want 5", sh_total - s0);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.sh, bus.sdi, bus.busy, bus.rx_done, bus.ferr} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_outputs got=%b want=00000", {bus.sh, bus.sdi, bus.busy, bus.rx_done, bus.ferr});
    end
    bus.rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (sh_total - s0 !== 5 || done_total - d0 !== 0 || obs_q.size() !== 0) begin
      errors++;
      $display("FAIL midreset_abort sh=%0d done=%0d obs=%0d want 5/0/0", sh_total - s0, done_total - d0, obs_q.size());
    end
    send_frame(8'h81, 1'b1);
    e = exp_q.pop_front();
    wait_obs(o, ok);
    checks++;
    if (!ok || {o.fr, o.ferr, o.nsh == 10, o.gaps == 0, o.dgap == 1} !== {e.fr, e.ferr, 3'b111}) begin
      errors++;
      $display("FAIL midreset_next ok=%b fr=%b ferr=%b nsh=%0d want fr=%b ferr=%b nsh=10", ok, o.fr, o.ferr, o.nsh, e.fr, e.ferr);
    end
  endtask
  task automatic test_break();
    obs_t o;
    exp_t e;
    bit ok;
    // Line low for 15 bit times: an all-zero frame with a bad stop bit, then an immediate
    // restart whose samples from d4 onward see the line released high (data 0xF0, stop 1).
    exp_q.push_back('{10'b0, 1'b1});
    exp_q.push_back('{{1'b1, 8'hF0, 1'b0}, 1'b0});
    align();
    bus.rx = 1'b0;
    repeat (15 * B) @(posedge clk);
    #1;
    bus.rx = 1'b1;
    repeat (2) begin
      e = exp_q.pop_front();
      wait_obs(o, ok);
      checks++;
      if (!ok || {o.fr, o.ferr, o.nsh == 10} !== {e.fr, e.ferr, 1'b1}) begin
        errors++;
        $display("FAIL break_frame ok=%b fr=%b ferr=%b nsh=%0d want fr=%b ferr=%b nsh=10", ok, o.fr, o.ferr, o.nsh, e.fr, e.ferr);
      end
    end
  endtask
  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_ferr();
    test_back_to_back();
    test_reset_mid();
    test_break();
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (overlap !== 0 || obs_q.size() !== 0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL final overlap=%0d obs_left=%0d exp_left=%0d want 0/0/0", overlap, obs_q.size(), exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
